// File: rtl/rvfi_trace_fifo_if.sv
// Handshake/bus bundle between the RVFI packer, the trace FIFO and the trace sink.
// Latency: none, wires only.
// Backpressure: the trace_ready_i/trace_valid_o pair carries it; the record lanes have none.
interface rvfi_trace_fifo_if #(
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned RecWidth     = 256,
  parameter int unsigned Depth        = 16,
  parameter int unsigned OrderWidth   = 64,
  parameter int unsigned DropCntWidth = 16
);
  localparam int unsigned LevelWidth = $clog2(Depth + 1);

  // Retirement side: one packed record per commit lane.
  logic [NrPorts-1:0]          rec_valid_i;
  logic [NrPorts*RecWidth-1:0] rec_i;
  logic                        clear_i;

  // Sink side: single-lane valid/ready drain.
  logic                        trace_valid_o;
  logic                        trace_ready_i;
  logic [RecWidth-1:0]         trace_rec_o;
  logic [OrderWidth-1:0]       trace_order_o;

  // Status.
  logic [LevelWidth-1:0]       level_o;
  logic                        overflow_o;
  logic [DropCntWidth-1:0]     drop_cnt_o;

  // Producer plus sink view (drives records, ready and clear).
  modport master (
    output rec_valid_i, rec_i, clear_i, trace_ready_i,
    input  trace_valid_o, trace_rec_o, trace_order_o, level_o, overflow_o, drop_cnt_o
  );

  // FIFO view.
  modport slave (
    input  rec_valid_i, rec_i, clear_i, trace_ready_i,
    output trace_valid_o, trace_rec_o, trace_order_o, level_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/rvfi_trace_fifo.sv
// Multi-lane RVFI retirement trace buffer: compacts valid lanes, stamps order, queues in a circular FIFO.
// Latency: a record pushed in cycle N is visible at the head in cycle N+1 at the earliest (no bypass).
// Backpressure: the sink stalls via trace_ready_i; the core is never stalled, whole groups drop on overflow.
module rvfi_trace_fifo #(
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned RecWidth     = 256,
  parameter int unsigned Depth        = 16,
  parameter int unsigned OrderWidth   = 64,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rvfi_trace_fifo_if.slave  bus
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LvlW  = $clog2(Depth + 1);
  localparam int unsigned CntW  = $clog2(NrPorts + 1);
  localparam int unsigned FreeW = LvlW + 1;
  localparam int unsigned SumW  = ((DropCntWidth > CntW) ? DropCntWidth : CntW) + 1;

  // Depth is a power of two, so masking implements modulo-Depth wrap (and pins Depth=1 to slot 0).
  localparam logic [PtrW-1:0] PtrMask = PtrW'(Depth - 1);

  // Architectural state.
  logic [PtrW-1:0]         wptr_q, wptr_d;
  logic [PtrW-1:0]         rptr_q, rptr_d;
  logic [LvlW-1:0]         level_q, level_d;
  logic [OrderWidth-1:0]   order_q, order_d;
  logic                    overflow_q, overflow_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

  // Storage is deliberately left unreset; validity is tracked by level_q alone.
  logic [RecWidth-1:0]     mem_rec [Depth];
  logic [OrderWidth-1:0]   mem_ord [Depth];

  // Per-lane compaction results.
  logic [CntW-1:0]         lane_idx [NrPorts];
  logic [PtrW-1:0]         wr_idx   [NrPorts];
  logic [OrderWidth-1:0]   lane_ord [NrPorts];
  logic [CntW-1:0]         n;

  logic                    head_vld;
  logic                    pop;
  logic [FreeW-1:0]        free;
  logic                    accept;
  logic                    drop;
  logic [DropCntWidth-1:0] drop_base;
  logic [SumW-1:0]         drop_sum;

  // Rank each valid lane among the valid lanes below it; the total is the group size.
  always_comb begin
    n        = '0;
    lane_idx = '{default: '0};
    for (int k = 0; k < NrPorts; k++) begin
      lane_idx[k] = n;
      if (bus.rec_valid_i[k]) begin
        n = n + CntW'(1);
      end
    end
  end

  // Slot and order stamp a lane would receive if its group is admitted.
  always_comb begin
    wr_idx   = '{default: '0};
    lane_ord = '{default: '0};
    for (int k = 0; k < NrPorts; k++) begin
      wr_idx[k]   = (wptr_q + PtrW'(lane_idx[k])) & PtrMask;
      lane_ord[k] = order_q + OrderWidth'(lane_idx[k]);
    end
  end

  assign head_vld = (level_q != '0);
  assign pop      = head_vld && bus.trace_ready_i;

  // A pop in the same cycle frees one slot, which is what lets a full FIFO admit a group of 1.
  assign free   = FreeW'(Depth) - FreeW'(level_q) + FreeW'(pop);
  assign accept = (FreeW'(n) <= free);
  assign drop   = !accept;   // n == 0 always fits, so a drop implies a non-empty group

  // Pointer, occupancy, order and loss-reporting next state.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    order_d    = order_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_base  = '0;
    drop_sum   = '0;

    if (accept) begin
      wptr_d = (wptr_q + PtrW'(n)) & PtrMask;
    end
    if (pop) begin
      rptr_d = (rptr_q + PtrW'(1)) & PtrMask;
    end
    level_d = level_q + (accept ? LvlW'(n) : LvlW'(0)) - LvlW'(pop);

    // Order advances even for dropped groups so the sink sees the loss as a gap.
    order_d = order_q + OrderWidth'(n);

    // Clear first, then a same-cycle drop overrides it.
    drop_base = bus.clear_i ? '0 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (bus.clear_i) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_sum   = SumW'(drop_base) + SumW'(n);
      if (drop_sum > SumW'({DropCntWidth{1'b1}})) begin
        drop_cnt_d = '1;
      end else begin
        drop_cnt_d = DropCntWidth'(drop_sum);
      end
    end
  end

  // Control state register; reset discards the queue and restarts order stamping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      order_q    <= order_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write every valid lane of an admitted group into its compacted slot.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < NrPorts; k++) begin
        if (bus.rec_valid_i[k]) begin
          mem_rec[wr_idx[k]] <= bus.rec_i[k*RecWidth +: RecWidth];
          mem_ord[wr_idx[k]] <= lane_ord[k];
        end
      end
    end
  end

  // Head is gated to zero while empty so the unreset storage never leaks out.
  assign bus.trace_valid_o = head_vld;
  assign bus.trace_rec_o   = head_vld ? mem_rec[rptr_q] : '0;
  assign bus.trace_order_o = head_vld ? mem_ord[rptr_q] : '0;
  assign bus.level_o       = level_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.drop_cnt_o    = drop_cnt_q;

  // Occupancy must stay within the physical queue.
  a_level_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    level_q <= LvlW'(Depth));

  // A held head must not change while the sink stalls.
  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (head_vld && !bus.trace_ready_i) |=> ($stable(bus.trace_order_o) && $stable(bus.trace_rec_o)));

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
module tb_rvfi_trace_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvfi_trace_fifo_if #(
    .NrPorts(2), .RecWidth(256), .Depth(16), .OrderWidth(64), .DropCntWidth(16)
  ) bus ();

  rvfi_trace_fifo #(
    .NrPorts(2), .RecWidth(256), .Depth(16), .OrderWidth(64), .DropCntWidth(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]   v;
    logic [255:0] r0;
    logic [255:0] r1;
    logic         rdy;
    logic         clr;
    logic         e_vld;
    logic [255:0] e_rec;
    logic [63:0]  e_ord;
    logic [4:0]   e_lvl;
    logic         e_ovf;
    logic [15:0]  e_drop;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [1:0] v, input logic [255:0] r0, input logic [255:0] r1,
                              input logic rdy, input logic clr, input logic e_vld,
                              input logic [255:0] e_rec, input logic [63:0] e_ord,
                              input logic [4:0] e_lvl, input logic e_ovf, input logic [15:0] e_drop);
    vec_t t;
    t.v = v; t.r0 = r0; t.r1 = r1; t.rdy = rdy; t.clr = clr;
    t.e_vld = e_vld; t.e_rec = e_rec; t.e_ord = e_ord; t.e_lvl = e_lvl;
    t.e_ovf = e_ovf; t.e_drop = e_drop;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
  task automatic step(input logic [1:0] v, input logic [255:0] r0, input logic [255:0] r1,
                      input logic rdy, input logic clr);
    bus.rec_valid_i   = v;
    bus.rec_i         = {r1, r0};
    bus.trace_ready_i = rdy;
    bus.clear_i       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string nm, input logic [4:0] lvl, input logic ovf,
                            input logic [15:0] drp);
    chk({nm, "_lvl"}, 256'(bus.level_o), 256'(lvl));
    chk({nm, "_ovf"}, 256'(bus.overflow_o), 256'(ovf));
    chk({nm, "_drop"}, 256'(bus.drop_cnt_o), 256'(drp));
  endtask

  initial begin
    logic [63:0] exp_ord;

    // Single lane, lane gap, backpressure hold and drain.
    tbl[0]  = mk(2'b01, 256'hA0, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA0, 64'd0, 5'd1, 1'b0, 16'd0);
    tbl[1]  = mk(2'b01, 256'hA1, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA1, 64'd1, 5'd1, 1'b0, 16'd0);
    tbl[2]  = mk(2'b01, 256'hA2, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA2, 64'd2, 5'd1, 1'b0, 16'd0);
    tbl[3]  = mk(2'b01, 256'hA3, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA3, 64'd3, 5'd1, 1'b0, 16'd0);
    tbl[4]  = mk(2'b01, 256'hA4, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA4, 64'd4, 5'd1, 1'b0, 16'd0);
    tbl[5]  = mk(2'b00, 256'h0,  256'h0, 1'b1, 1'b0, 1'b0, 256'h0,  64'd0, 5'd0, 1'b0, 16'd0);
    tbl[6]  = mk(2'b10, 256'h0,  256'hB, 1'b0, 1'b0, 1'b1, 256'hB,  64'd5, 5'd1, 1'b0, 16'd0);
    tbl[7]  = mk(2'b11, 256'hC,  256'hD, 1'b0, 1'b0, 1'b1, 256'hB,  64'd5, 5'd3, 1'b0, 16'd0);
    tbl[8]  = mk(2'b00, 256'h0,  256'h0, 1'b0, 1'b0, 1'b1, 256'hB,  64'd5, 5'd3, 1'b0, 16'd0);
    tbl[9]  = mk(2'b00, 256'h0,  256'h0, 1'b1, 1'b0, 1'b1, 256'hC,  64'd6, 5'd2, 1'b0, 16'd0);
    tbl[10] = mk(2'b00, 256'h0,  256'h0, 1'b1, 1'b0, 1'b1, 256'hD,  64'd7, 5'd1, 1'b0, 16'd0);
    tbl[11] = mk(2'b00, 256'h0,  256'h0, 1'b1, 1'b0, 1'b0, 256'h0,  64'd0, 5'd0, 1'b0, 16'd0);

    bus.rec_valid_i   = '0;
    bus.rec_i         = '0;
    bus.trace_ready_i = 1'b0;
    bus.clear_i       = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 256'(bus.trace_valid_o), 256'(0));
    chk("rst_rec", bus.trace_rec_o, 256'h0);
    chk("rst_ord", 256'(bus.trace_order_o), 256'h0);
    chk_status("rst", 5'd0, 1'b0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("v%0d_vld", i), 256'(bus.trace_valid_o), 256'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_rec", i), bus.trace_rec_o, tbl[i].e_rec);
        chk($sformatf("v%0d_ord", i), 256'(bus.trace_order_o), 256'(tbl[i].e_ord));
      end
      chk_status($sformatf("v%0d", i), tbl[i].e_lvl, tbl[i].e_ovf, tbl[i].e_drop);
    end

    // Reset mid-stream: queue empties at once, stamping restarts at 0.
    step(2'b11, 256'h61, 256'h62, 1'b0, 1'b0);
    step(2'b11, 256'h63, 256'h64, 1'b0, 1'b0);
    chk("pre_rst_lvl", 256'(bus.level_o), 256'(4));
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 256'(bus.trace_valid_o), 256'(0));
    chk("mid_rst_lvl", 256'(bus.level_o), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b01, 256'h55, 256'h0, 1'b0, 1'b0);
    chk("post_rst_rec", bus.trace_rec_o, 256'h55);
    chk("post_rst_ord", 256'(bus.trace_order_o), 256'(0));
    chk("post_rst_lvl", 256'(bus.level_o), 256'(1));

    // Clean slate for the overflow sequence.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to 15 (orders 0..14) with the sink stalled.
    for (int g = 0; g < 7; g++) begin
      step(2'b11, 256'(16'h100 + 2 * g), 256'(16'h101 + 2 * g), 1'b0, 1'b0);
    end
    step(2'b01, 256'h10E, 256'h0, 1'b0, 1'b0);
    chk_status("fill15", 5'd15, 1'b0, 16'd0);
    chk("fill15_ord", 256'(bus.trace_order_o), 256'(0));

    // Two-record group does not fit in one free slot: dropped whole (orders 15,16).
    step(2'b11, 256'hDEAD, 256'hBEEF, 1'b0, 1'b0);
    chk_status("ovf_drop", 5'd15, 1'b1, 16'd2);

    // Next accepted record carries order 17 and fills the queue.
    step(2'b01, 256'h177, 256'h0, 1'b0, 1'b0);
    chk_status("full16", 5'd16, 1'b1, 16'd2);

    // Full with a pop admits a group of 1 (order 18).
    step(2'b01, 256'h188, 256'h0, 1'b1, 1'b0);
    chk_status("full_pop1", 5'd16, 1'b1, 16'd2);
    chk("full_pop1_ord", 256'(bus.trace_order_o), 256'(1));

    // Full with a pop still rejects a group of 2 (orders 19,20).
    step(2'b11, 256'h199, 256'h200, 1'b1, 1'b0);
    chk_status("full_pop2", 5'd15, 1'b1, 16'd4);

    // Drain: orders 2..14, then 17 and 18 expose the gaps.
    for (int i = 0; i < 15; i++) begin
      exp_ord = (i < 13) ? 64'(i + 2) : ((i == 13) ? 64'd17 : 64'd18);
      chk($sformatf("drain%0d_ord", i), 256'(bus.trace_order_o), 256'(exp_ord));
      if (i == 13) chk("drain_rec17", bus.trace_rec_o, 256'h177);
      if (i == 14) chk("drain_rec18", bus.trace_rec_o, 256'h188);
      step(2'b00, 256'h0, 256'h0, 1'b1, 1'b0);
    end
    chk("drained_vld", 256'(bus.trace_valid_o), 256'(0));
    chk("drained_lvl", 256'(bus.level_o), 256'(0));

    // Plain clear.
    step(2'b00, 256'h0, 256'h0, 1'b0, 1'b1);
    chk_status("clear", 5'd0, 1'b0, 16'd0);

    // Fill to 16, then clear colliding with a dropped group: drop wins.
    for (int g = 0; g < 8; g++) begin
      step(2'b11, 256'(16'h300 + 2 * g), 256'(16'h301 + 2 * g), 1'b0, 1'b0);
    end
    chk_status("fill16", 5'd16, 1'b0, 16'd0);
    step(2'b11, 256'h3F0, 256'h3F1, 1'b0, 1'b1);
    chk_status("clr_drop", 5'd16, 1'b1, 16'd2);

    // Full with no pop drops even a single record.
    step(2'b01, 256'h3F2, 256'h0, 1'b0, 1'b0);
    chk_status("full_nopop", 5'd16, 1'b1, 16'd3);
    chk("full_nopop_rec", bus.trace_rec_o, 256'h300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
